mul_iter_unit: RTL

Iterative shift-add multiplier serving the accelerator's `mul` instruction (OpCode 0x1c, Funct 0x02). It sits directly downstream of the control decoder. The datapath asserts `start` while the decoded instruction is `mul`. The unit holds the PC/writeback through `stall` until the product is ready, then presents the low WIDTH bits for register writeback in a single `done` cycle.

---
 rtl/mul_iter_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/mul_iter_unit.sv
// Iterative shift-add multiplier for the mul instruction: one partial-product step per cycle.
// Define MUL_EARLY_EXIT_EN to end the run once the remaining multiplier bits are all zero.
module mul_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic [WIDTH-1:0] accP;
  logic [WIDTH-1:0] nextP;
  logic [WIDTH-1:0] nextB;
  logic [CW-1:0]    count;
  logic             lastIter;
  logic             finish;

  assign nextP    = regB[0] ? accP + regA : accP;
  assign nextB    = regB >> 1;
  assign lastIter = (count == CW'(WIDTH - 1));

`ifdef MUL_EARLY_EXIT_EN
  assign finish = lastIter || (nextB == '0);
`else
  assign finish = lastIter;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // stall follows start combinationally in IDLE so the mul is frozen from its first cycle
  always_comb begin
    stateNext = state;
    stall     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        stall = start;
        if (start) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        stall = 1'b1;
        busy  = 1'b1;
        if (finish) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regA   <= '0;
      regB   <= '0;
      accP   <= '0;
      count  <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            regA  <= in_a;
            regB  <= in_b;
            accP  <= '0;
            count <= '0;
          end
        end
        RUN: begin
          regA  <= regA << 1;
          regB  <= nextB;
          accP  <= nextP;
          count <= count + CW'(1);
          // result only moves on the DONE entry, so an aborted run never shows up
          if (finish) begin
            result <= nextP;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
